// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the four-way round-robin mux arbiter.
// Covers the state encodings, the owner index width and the one-hot decode.
package mux4_rr_arbiter_pkg;

  localparam int IDX_W = 2;

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_GRANT = 1'b1;

  function automatic logic [3:0] onehot4(input logic [IDX_W-1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// Rotating priority encoder.
// Returns the first set request bit found scanning from ptr upward, wrapping 3 -> 0.
module mux4_rr_arbiter_rr_pick
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [3:0]       req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [6:0]       dbl_s;
  logic [3:0]       rot_s;
  logic [IDX_W-1:0] off_s;

  // rot_s[k] is the request at position ptr+k (mod 4)
  assign dbl_s = {req[2:0], req};
  assign rot_s = dbl_s[ptr +: 4];

  // Distance from ptr to the first waiting requester
  always_comb begin
    off_s = 2'd0;
    if (rot_s[0]) begin
      off_s = 2'd0;
    end else if (rot_s[1]) begin
      off_s = 2'd1;
    end else if (rot_s[2]) begin
      off_s = 2'd2;
    end else if (rot_s[3]) begin
      off_s = 2'd3;
    end else begin
      off_s = 2'd0;
    end
  end

  assign idx = ptr + off_s;
  assign any = |req;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select pair of a shared 4-to-1 mux.
// It grants one owner at a time and caps each grant at HOLD_MAX cycles while others wait.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       busy
);

  if (HOLD_MAX < 1 || HOLD_MAX > 7 || (2 ** CNT_W) <= HOLD_MAX) begin : g_bad_params
    $error("mux4_rr_arbiter: HOLD_MAX must be 1..7 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(HOLD_MAX - 1);

  logic             state_r, state_nxt_s;
  logic [IDX_W-1:0] ptr_r, ptr_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [3:0]       gnt_r, gnt_nxt_s;
  logic [IDX_W-1:0] sel_r, sel_nxt_s;
  logic             busy_r, busy_nxt_s;

  logic [IDX_W-1:0] pick_ptr_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_any_s;
  logic [3:0]       others_s;
  logic             release_s;

  // While granting, the handoff search starts just past the current owner
  assign pick_ptr_s = (state_r == STATE_GRANT) ? (sel_r + 2'd1) : ptr_r;

  mux4_rr_arbiter_rr_pick u_pick (
    .req (req),
    .ptr (pick_ptr_s),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  assign others_s  = req & ~gnt_r;
  assign release_s = ~req[sel_r] | ((cnt_r == CNT_LIM) & (|others_s));

  // Next-state decision for FSM, pointer, hold counter and outputs
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    cnt_nxt_s   = cnt_r;
    gnt_nxt_s   = gnt_r;
    sel_nxt_s   = sel_r;
    busy_nxt_s  = busy_r;
    case (state_r)
      STATE_IDLE: begin
        if (pick_any_s) begin
          state_nxt_s = STATE_GRANT;
          gnt_nxt_s   = onehot4(pick_idx_s);
          sel_nxt_s   = pick_idx_s;
          busy_nxt_s  = 1'b1;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = STATE_IDLE;
        end
      end
      STATE_GRANT: begin
        if (release_s) begin
          ptr_nxt_s = sel_r + 2'd1;
          cnt_nxt_s = {CNT_W{1'b0}};
          if (|others_s) begin
            gnt_nxt_s = onehot4(pick_idx_s);
            sel_nxt_s = pick_idx_s;
          end else begin
            state_nxt_s = STATE_IDLE;
            gnt_nxt_s   = 4'b0000;
            busy_nxt_s  = 1'b0;
          end
        end else if (cnt_r != CNT_LIM) begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        state_nxt_s = STATE_IDLE;
        gnt_nxt_s   = 4'b0000;
        busy_nxt_s  = 1'b0;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers; reset drops any grant immediately
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= STATE_IDLE;
      ptr_r   <= 2'd0;
      cnt_r   <= {CNT_W{1'b0}};
      gnt_r   <= 4'b0000;
      sel_r   <= 2'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      cnt_r   <= cnt_nxt_s;
      gnt_r   <= gnt_nxt_s;
      sel_r   <= sel_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  assign gnt  = gnt_r;
  assign s1   = sel_r[1];
  assign s0   = sel_r[0];
  assign busy = busy_r;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed table, corner sequences, and random traffic.
// Random traffic is checked against an owner/hold-time reference model.
module tb_mux4_rr_arbiter;

  localparam int HOLD = 4;

  logic       clock;
  logic       reset_n;
  logic [3:0] req, req1;
  logic [3:0] gnt, gnt1;
  logic       s1, s0, busy;
  logic       s1_1, s0_1, busy1;

  int vectors;
  int miscompares;

  mux4_rr_arbiter #(.HOLD_MAX(4), .CNT_W(3)) dut (
    .clock(clock), .reset_n(reset_n), .req(req),
    .gnt(gnt), .s1(s1), .s0(s0), .busy(busy)
  );

  mux4_rr_arbiter #(.HOLD_MAX(1), .CNT_W(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .req(req1),
    .gnt(gnt1), .s1(s1_1), .s0(s0_1), .busy(busy1)
  );

  // Shared datapath mux driven by the HOLD_MAX=1 arbiter
  logic [7:0] mux_out;
  always_comb begin
    case ({s1_1, s0_1})
      2'd0:    mux_out = 8'hA5;
      2'd1:    mux_out = 8'h3C;
      2'd2:    mux_out = 8'h96;
      default: mux_out = 8'h0F;
    endcase
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: owner (-1 when idle), cycles held so far, pointer, last owner.
  int         m_owner, m_ptr, m_held;
  logic [1:0] m_last;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_held = 0; m_last = 2'd0;
  endtask

  task automatic model_step(input logic [3:0] r);
    int j;
    logic [3:0] oth;
    if (m_owner < 0) begin
      j = pick(r, m_ptr);
      if (j >= 0) begin
        m_owner = j; m_held = 1; m_last = 2'(j);
      end
    end else begin
      oth = r;
      oth[m_owner] = 1'b0;
      if (!r[m_owner] || (m_held >= HOLD && oth != 4'b0000)) begin
        m_ptr = (m_owner + 1) % 4;
        j = pick(oth, m_ptr);
        if (j >= 0) begin
          m_owner = j; m_held = 1; m_last = 2'(j);
        end else begin
          m_owner = -1;
        end
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic chk(input string name, input logic [3:0] eg, input logic [1:0] es, input logic eb);
    vectors++;
    if (gnt !== eg || {s1, s0} !== es || busy !== eb) begin
      miscompares++;
      $display("FAIL %s: got gnt=%b s1s0=%b busy=%b, want gnt=%b s1s0=%b busy=%b",
               name, gnt, {s1, s0}, busy, eg, es, eb);
    end
  endtask

  task automatic chk_model(input string name);
    logic [3:0] eg;
    eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    chk(name, eg, m_last, (m_owner >= 0));
  endtask

  // Drive req clear of the edge, let one edge pass, advance the model.
  task automatic tick(input logic [3:0] r);
    req = r;
    @(posedge clock);
    #1;
    model_step(r);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    chk("reset_state", 4'b0000, 2'b00, 1'b0);
    reset_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] r, input logic [3:0] g,
                              input logic [1:0] s, input logic b);
    vec_t v;
    v.rst = rst; v.req = r; v.gnt = g; v.sel = s; v.busy = b;
    return v;
  endfunction

  initial begin
    logic [3:0] rr;
    logic       seen;
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    req = 4'b0000;
    req1 = 4'b0000;
    model_reset();

    // Single request, then release: s1s0 keeps the last owner.
    tbl.push_back(mk(1'b1, 4'b0100, 4'b0100, 2'b10, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 2'b10, 1'b0));
    // All four requesting: each owner holds 4 cycles, no gap, order 0,1,2,3,0.
    for (int k = 0; k < 17; k++) begin
      tbl.push_back(mk((k == 0), 4'b1111, 4'b0001 << ((k / 4) % 4), 2'((k / 4) % 4), 1'b1));
    end
    // Owner 1 drops as 1001 arrives: search starts at 2, so owner 3 wins.
    tbl.push_back(mk(1'b1, 4'b0010, 4'b0010, 2'b01, 1'b1));
    tbl.push_back(mk(1'b0, 4'b1001, 4'b1000, 2'b11, 1'b1));

    @(posedge clock);
    #1;
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      tick(tbl[i].req);
      chk($sformatf("table[%0d]", i), tbl[i].gnt, tbl[i].sel, tbl[i].busy);
    end

    // Uncontended owner keeps the grant, then yields within HOLD edges.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      tick(4'b0001);
      chk("uncontended_hold", 4'b0001, 2'b00, 1'b1);
    end
    seen = 1'b0;
    for (int e = 0; e < HOLD && !seen; e++) begin
      tick(4'b0101);
      if (gnt === 4'b0100 && {s1, s0} === 2'b10) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL late_contender: got gnt=%b s1s0=%b, want gnt=0100 s1s0=10 within %0d edges",
               gnt, {s1, s0}, HOLD);
    end

    // Asynchronous reset in the middle of a grant.
    do_reset();
    for (int k = 0; k < 3; k++) tick(4'b1000);
    chk("pre_async_reset", 4'b1000, 2'b11, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_drop", 4'b0000, 2'b00, 1'b0);
    #1;
    reset_n = 1'b1;
    model_reset();
    tick(4'b1000);
    chk("post_reset_grant", 4'b1000, 2'b11, 1'b1);

    // HOLD_MAX=1: two requesters alternate every cycle; mux follows the select.
    do_reset();
    req = 4'b0000;
    req1 = 4'b0011;
    for (int k = 0; k < 8; k++) begin
      @(posedge clock);
      #1;
      vectors++;
      if (gnt1 !== ((k % 2 == 0) ? 4'b0001 : 4'b0010) ||
          {s1_1, s0_1} !== 2'(k % 2) || busy1 !== 1'b1 ||
          mux_out !== ((k % 2 == 0) ? 8'hA5 : 8'h3C)) begin
        miscompares++;
        $display("FAIL hold1_alternate[%0d]: got gnt=%b s1s0=%b busy=%b mux=%h, want owner %0d",
                 k, gnt1, {s1_1, s0_1}, busy1, mux_out, k % 2);
      end
    end
    req1 = 4'b0000;

    // Random traffic against the reference model.
    do_reset();
    rr = 4'b0000;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) rr = 4'($urandom);
      tick(rr);
      chk_model($sformatf("random[%0d] req=%b", k, rr));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
